// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Holds the FSM state encoding, the verdict encoding and the default operand width.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    VERD_EQ = 2'b00,
    VERD_LT = 2'b01,
    VERD_GT = 2'b10
  } verdict_t;

  localparam int CMP_WIDTH = 6;

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit unsigned compare cell, purely combinational.
// Reports whether bit a is strictly greater or strictly less than bit b.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator: walks two WIDTH-bit operands LSB-first,
// one bit per clock, and presents a one-hot less/equal/greater verdict under valid/ready.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  verdict_t           verdict;
  verdict_t           verdict_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   cnt;
  logic               bit_gt;
  logic               bit_lt;
  logic               last_bit;

  cmp_bit_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .gt (bit_gt),
    .lt (bit_lt)
  );

  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
  assign start_ready = (state == IDLE);
  assign busy        = (state == SHIFT);
  assign res_valid   = (state == DONE);

  // Any differing bit overwrites the verdict, so the most significant difference wins.
  always_comb begin
    verdict_nxt = verdict;
    if (bit_gt) begin
      verdict_nxt = VERD_GT;
    end else if (bit_lt) begin
      verdict_nxt = VERD_LT;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Verdict outputs are only rewritten at accept (cleared) and on the last shift (loaded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      verdict <= VERD_EQ;
      a_lt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
      a_gt_b  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            cnt     <= '0;
            verdict <= VERD_EQ;
            a_lt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            a_gt_b  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + CNT_W'(1);
          verdict <= verdict_nxt;
          if (last_bit) begin
            a_lt_b <= (verdict_nxt == VERD_LT);
            a_eq_b <= (verdict_nxt == VERD_EQ);
            a_gt_b <= (verdict_nxt == VERD_GT);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare: accepted operand pairs are queued with their
// accept cycle, and a monitor compares each presented verdict against plain arithmetic.
module tb_serial_mag_compare;

  localparam int W      = 6;
  localparam int BUDGET = 200;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } entry_t;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         res_valid;
  logic         res_ready;
  logic         a_lt_b;
  logic         a_eq_b;
  logic         a_gt_b;
  logic         busy;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     accepts = 0;
  bit     rand_ready = 0;
  bit     prev_valid = 0;
  entry_t exp_q[$];

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .a_gt_b      (a_gt_b),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    if (ia < ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Records accepts into the scoreboard and checks whatever verdict is being presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_valid && start_ready) begin
        exp_q.push_back('{a: a_in, b: b_in, acc: cyc + 1});
        accepts++;
      end
      if (busy) begin
        checkOutput("shift_verdict_zero", {29'd0, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          checkOutput("verdict", {29'd0, a_lt_b, a_eq_b, a_gt_b},
                      {29'd0, model(exp_q[0].a, exp_q[0].b)});
          checkOutput("onehot", {31'd0, $onehot({a_lt_b, a_eq_b, a_gt_b})}, 32'd1);
          checkOutput("start_ready_in_done", {31'd0, start_ready}, 32'd0);
          if (!prev_valid) begin
            checkOutput("latency", cyc - exp_q[0].acc, W);
          end
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = res_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic randReady();
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at posedge+1; holds the pair until the block takes it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bit taken = 0;
    a_in = a;
    b_in = b;
    start_valid = 1'b1;
    while (!taken && n < BUDGET) begin
      @(negedge clk);
      if (start_ready) begin
        taken = 1;
      end else begin
        @(posedge clk);
        #1;
        randReady();
        n++;
      end
    end
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    randReady();
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc0;
    bit seen;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    res_ready = 1'b1;
    #12;
    checkOutput("reset_outputs", {27'd0, res_valid, a_lt_b, a_eq_b, a_gt_b, busy}, 32'd0);
    checkOutput("reset_start_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed pairs, each run to completion.
    applyStimulus(6'd5, 6'd9);
    waitDrain();
    applyStimulus(6'd63, 6'd0);
    waitDrain();
    applyStimulus(6'd42, 6'd42);
    waitDrain();
    applyStimulus(6'd32, 6'd31);
    waitDrain();
    applyStimulus(6'd1, 6'd2);
    waitDrain();

    // Backpressure with a waiting source whose operands keep changing.
    acc0 = accepts;
    res_ready = 1'b0;
    applyStimulus(6'd20, 6'd40);
    seen = 0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    checkOutput("bp_result_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(posedge clk);
      #1;
    end
    checkOutput("bp_no_second_accept", accepts - acc0, 32'd1);
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (start_ready) seen = 1;
    end
    checkOutput("bp_release_accept", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    waitDrain();
    checkOutput("bp_accept_count", accepts - acc0, 32'd2);

    // Reset in the third SHIFT cycle discards the operation.
    applyStimulus(6'd7, 6'd12);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midop_reset_outputs", {27'd0, res_valid, a_lt_b, a_eq_b, a_gt_b, busy}, 32'd0);
    checkOutput("midop_reset_start_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(6'd12, 6'd7);
    waitDrain();

    // Exhaustive sweep, back to back.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        applyStimulus(W'(a), W'(b));
      end
    end
    waitDrain();

    // Random operands with random consumer backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(W'($urandom), W'($urandom));
    end
    rand_ready = 0;
    res_ready = 1'b1;
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
